// File: rtl/fetch_buffer.sv
// fetch_buffer: one-outstanding instruction fetch feeding a first-word-fall-through {pc, inst} FIFO.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned PCs skip memory and enqueue a NOP tagged inst_misalign.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        inst_misalign,
`endif
  input  logic        inst_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic          accept, issue, push, pop;
  logic [31:0]   push_pc, push_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          mem_mis [DEPTH];
  logic          push_mis;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    push_pc   = imem_addr;
    push_inst = imem_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
    push_mis  = 1'b0;
`endif
    pc_ready  = !rst && (state == IDLE) && (count < FULL) && !flush;
    accept    = pc_valid && pc_ready;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (pc_in[1:0] != 2'b00) begin
            push      = 1'b1;
            push_pc   = pc_in;
            push_inst = NOP;
            push_mis  = 1'b1;
          end else begin
            issue     = 1'b1;
            state_nxt = WAIT;
          end
`else
          issue     = 1'b1;
          state_nxt = WAIT;
`endif
        end
      end
      WAIT: begin
        // a flush coinciding with the ack simply discards the returned word
        if (imem_ack) begin
          state_nxt = IDLE;
          push      = !flush;
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      imem_req <= (state_nxt != IDLE);
      if (issue) imem_addr <= pc_in;
    end
  end

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !flush;
  assign inst_out   = mem_inst[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
`ifdef FETCH_ALIGN_CHECK_EN
  assign inst_misalign = mem_mis[rd_ptr];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
        mem_mis[i]  <= 1'b0;
`endif
      end
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= push_pc;
        mem_inst[wr_ptr] <= push_inst;
`ifdef FETCH_ALIGN_CHECK_EN
        mem_mis[wr_ptr]  <= push_mis;
`endif
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer: latency, full FIFO, wrap, flush cases, async reset.
module tb_fetch_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        inst_misalign;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .flush(flush), .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .inst_misalign(inst_misalign),
`endif
    .inst_ready(inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // accept pc, wait w cycles in WAIT, then ack with d
  task automatic fetch(input logic [31:0] pc, input logic [31:0] d, input int w);
    pc_valid = 1'b1;
    pc_in    = pc;
    tick();
    pc_valid = 1'b0;
    repeat (w) tick();
    imem_ack   = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_in = '0; pc_valid = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    flush = 1'b0; inst_ready = 1'b0;
    #1;
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_out", inst_out, 0);
    chk("rst_inst_pc", inst_pc, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("idle_pc_ready", pc_ready, 1);

    // single fetch, ack one cycle after req start
    pc_valid = 1'b1; pc_in = 32'h0;
    tick();
    pc_valid = 1'b0;
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_busy_pc_ready", pc_ready, 0);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    #1;
    chk("t1_valid_before", inst_valid, 0);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("t1_valid", inst_valid, 1);
    chk("t1_pc", inst_pc, 32'h0);
    chk("t1_inst", inst_out, 32'h0050_0093);
    chk("t1_req_drop", imem_req, 0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("t1_popped", inst_valid, 0);

    // fill FIFO to DEPTH
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 32'h1000 + 32'(i), 0);
    pc_valid = 1'b1; pc_in = 32'h10;
    #1;
    chk("full_count", dut.count, 4);
    chk("full_pc_ready", pc_ready, 0);
    chk("full_head", inst_pc, 32'h0);
    tick();
    pc_valid = 1'b0;
    #1;
    chk("full_no_req", imem_req, 0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("after_pop_pc_ready", pc_ready, 1);
    for (int i = 1; i < 4; i++) begin
      chk("drain_pc", inst_pc, 32'(i * 4));
      chk("drain_inst", inst_out, 32'h1000 + 32'(i));
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      #1;
    end
    chk("drain_empty", inst_valid, 0);

    // simultaneous push/pop at count 2, write pointer wraps 3 -> 0
    fetch(32'h100, 32'hA1, 0);
    fetch(32'h104, 32'hB2, 0);
    #1;
    chk("wrap_count2", dut.count, 2);
    chk("wrap_wp3", dut.wr_ptr, 3);
    pc_valid = 1'b1; pc_in = 32'h10C;
    tick();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hD4; inst_ready = 1'b1;
    #1;
    chk("wrap_head_a", inst_pc, 32'h100);
    tick();
    imem_ack = 1'b0; inst_ready = 1'b0;
    #1;
    chk("wrap_count_same", dut.count, 2);
    chk("wrap_wp0", dut.wr_ptr, 0);
    chk("wrap_head_b", inst_pc, 32'h104);
    chk("wrap_inst_b", inst_out, 32'hB2);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("wrap_head_d", inst_pc, 32'h10C);
    chk("wrap_inst_d", inst_out, 32'hD4);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("wrap_empty", inst_valid, 0);

    // flush while waiting, ack three cycles later is dropped
    pc_valid = 1'b1; pc_in = 32'h20;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("drop_state", dut.state, 2);
    chk("drop_req_held", imem_req, 1);
    chk("drop_pc_ready", pc_ready, 0);
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("drop_no_push", inst_valid, 0);
    chk("drop_req_off", imem_req, 0);
    chk("drop_idle", dut.state, 0);
    fetch(32'h40, 32'h4040_4040, 1);
    #1;
    chk("post_drop_pc", inst_pc, 32'h40);
    chk("post_drop_inst", inst_out, 32'h4040_4040);

    // flush coinciding with ack, two entries buffered
    fetch(32'h44, 32'h4444_4444, 0);
    #1;
    chk("fa_count2", dut.count, 2);
    pc_valid = 1'b1; pc_in = 32'h48;
    tick();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h4848_4848; flush = 1'b1;
    tick();
    imem_ack = 1'b0; flush = 1'b0;
    #1;
    chk("fa_count0", dut.count, 0);
    chk("fa_valid", inst_valid, 0);
    chk("fa_state", dut.state, 0);
    chk("fa_req", imem_req, 0);

    // flush in IDLE blocks acceptance
    pc_valid = 1'b1; pc_in = 32'h50; flush = 1'b1;
    #1;
    chk("idle_flush_pc_ready", pc_ready, 0);
    tick();
    pc_valid = 1'b0; flush = 1'b0;
    #1;
    chk("idle_flush_no_req", imem_req, 0);

    // stray ack without a request
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("stray_ack", inst_valid, 0);

    // asynchronous reset abandons an outstanding request
    pc_valid = 1'b1; pc_in = 32'h60;
    tick();
    pc_valid = 1'b0;
    #1;
    chk("ar_req_on", imem_req, 1);
    rst = 1'b1;
    #1;
    chk("ar_req_off", imem_req, 0);
    chk("ar_pc_ready", pc_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("ar_state", dut.state, 0);

`ifdef FETCH_ALIGN_CHECK_EN
    pc_valid = 1'b1; pc_in = 32'h6;
    tick();
    pc_valid = 1'b0;
    #1;
    chk("mis_no_req", imem_req, 0);
    chk("mis_valid", inst_valid, 1);
    chk("mis_pc", inst_pc, 32'h6);
    chk("mis_inst", inst_out, 32'h0000_0013);
    chk("mis_flag", inst_misalign, 1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    fetch(32'h8, 32'h0000_0888, 0);
    #1;
    chk("align_flag", inst_misalign, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction-fetch front end that consumes the address produced by the program counter register and returns instructions to decode. It accepts one PC at a time, runs a req/ack read on the instruction memory port, and pushes each {pc, instruction} pair into a first-word-fall-through FIFO for the decode stage. A flush input discards buffered and in-flight fetches on branch redirect.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset; asynchronous, active-high
- pc_in  input  32  fetch address from the program counter
- pc_valid  input  1  pc_in is valid
- pc_ready  output  1  PC accepted this cycle when pc_valid && pc_ready
- imem_req  output  1  memory read request, registered
- imem_addr  output  32  memory read address, registered
- imem_ack  input  1  memory read complete; imem_rdata valid this cycle
- imem_rdata  input  32  instruction word
- flush  input  1  discard all buffered and in-flight fetches
- inst_valid  output  1  FIFO head valid
- inst_out  output  32  FIFO head instruction
- inst_pc  output  32  FIFO head PC
- inst_ready  input  1  decode consumes the head when inst_valid && inst_ready

## Operation
- FSM states: IDLE, WAIT, DROP.
- pc_ready = (state == IDLE) && (count < DEPTH) && !flush.
- IDLE: on pc_valid && pc_ready, register imem_addr <= pc_in, imem_req <= 1, go to WAIT.
- WAIT: imem_req and imem_addr held stable until imem_ack. On imem_ack (no flush), push {imem_addr, imem_rdata}, drop imem_req, go to IDLE.
- DROP: imem_req held until imem_ack; the returned data is discarded; go to IDLE. pc_ready is 0.
- Flush, any state: count, read pointer and write pointer cleared; pop and push ignored that cycle. WAIT with no ack goes to DROP. WAIT with ack in the same cycle discards the data and goes to IDLE. A flush in IDLE blocks acceptance that cycle.
- FIFO: inst_valid = (count != 0). inst_out/inst_pc are the head entry (combinational read).
  - Pop on inst_valid && inst_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Overflow cannot occur: acceptance requires count < DEPTH, and at most one fetch is outstanding.
- imem_ack while imem_req is 0 is ignored.

## Timing
- Reset values: state IDLE; count, pointers 0; imem_req 0; imem_addr 0; inst_valid 0; inst_out 0; inst_pc 0; pc_ready 0 while rst is high.
- A PC accepted in cycle N drives imem_req in N+1.
- An ack in cycle M (M >= N+1; zero-wait ack in the first req cycle is legal) makes the entry visible at the FIFO head in M+1.
- Peak throughput is one fetch per 2 cycles with a zero-wait memory.
- rst asserted mid-fetch abandons the request immediately; imem_req drops asynchronously.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - Adds output inst_misalign (1 bit, reset 0), stored per FIFO entry.
  - An accepted pc_in with pc_in[1:0] != 0 issues no memory request and stays in IDLE.
  - It pushes {pc_in, 32'h0000_0013} with inst_misalign = 1 on the next edge; aligned entries carry 0.
- Undefined: the port is absent and pc_in is forwarded to imem_addr unchecked.

## Test plan
- Reset, then PC 0x0 with ack one cycle after req, rdata 0x00500093 -> inst_valid rises 2 cycles after ack+req start; inst_pc = 0x0, inst_out = 0x00500093.
- Four fetches 0x0/0x4/0x8/0xC with inst_ready = 0, DEPTH = 4 -> count reaches 4 and pc_ready stays 0. One pop -> pc_ready returns to 1 and entries drain in order.
- Flush in WAIT, ack 3 cycles later -> state DROP; ack data is not pushed; inst_valid is 0; the next PC 0x40 is fetched normally.
- Flush in the same cycle as an ack, with 2 entries buffered -> count becomes 0, no push, state IDLE.
- Push and pop in the same cycle with count = 2 -> count stays 2; the write pointer wraps from 3 to 0 correctly.
- With FETCH_ALIGN_CHECK_EN, PC 0x6 -> no imem_req; head shows inst_pc = 0x6, inst_out = 0x00000013, inst_misalign = 1.
